// File: rtl/blink_inv_shuffle_iter.sv
// blink_inv_shuffle_iter
//   Iterative cell-shuffle engine for the Blink-128 datapath. A 128-bit
//   state is held as 32 four-bit cells (cell k = state[4k+3:4k]). The
//   engine applies the inverse cell permutation once per clock for a
//   programmed number of rounds, then presents the result.
//
//   Optional macro BLINK_SHUFFLE_FWD_EN adds the in_dir port. When it is
//   set at accept, forward rounds are applied instead of inverse rounds.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   job offered
//   in_ready   engine idle, can accept a job
//   in_data    128-bit state to shuffle
//   in_rounds  number of permutation applications (0 passes data through)
//   in_dir     (BLINK_SHUFFLE_FWD_EN only) 1 = forward, 0 = inverse
//   out_valid  result available, held until out_ready
//   out_ready  downstream accepts result
//   out_data   shuffled state, driven from the state register at all times
//   busy       high while a job is running or waiting to be taken
module blink_inv_shuffle_iter #(
    parameter int ROUND_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_data,
    input  logic [ROUND_W-1:0] in_rounds,
`ifdef BLINK_SHUFFLE_FWD_EN
    input  logic               in_dir,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_data,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    // Forward table: forward round moves cell P[i] to cell i,
    // inverse round moves cell i to cell P[i].
    localparam logic [4:0] PERM [32] = '{
        5'h05, 5'h0c, 5'h04, 5'h01, 5'h11, 5'h09, 5'h0a, 5'h10,
        5'h1c, 5'h0e, 5'h15, 5'h16, 5'h0b, 5'h1b, 5'h08, 5'h0d,
        5'h02, 5'h19, 5'h12, 5'h03, 5'h1e, 5'h06, 5'h13, 5'h14,
        5'h00, 5'h17, 5'h18, 5'h1f, 5'h07, 5'h0f, 5'h1d, 5'h1a
    };

    fsm_t               fsm_q, fsm_d;
    logic [127:0]       state_q;
    logic [ROUND_W-1:0] cnt_q;
    logic               accept;

    logic [31:0][3:0]   cur_c, inv_c, nxt_c;

    assign cur_c = state_q;

    // Pure wiring: each output cell is a renamed input cell.
    always_comb begin
        inv_c = '0;
        for (int i = 0; i < 32; i++) inv_c[PERM[i]] = cur_c[i];
    end

`ifdef BLINK_SHUFFLE_FWD_EN
    logic             dir_q;
    logic [31:0][3:0] fwd_c;

    always_comb begin
        fwd_c = '0;
        for (int i = 0; i < 32; i++) fwd_c[i] = cur_c[PERM[i]];
    end

    assign nxt_c = dir_q ? fwd_c : inv_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      dir_q <= 1'b0;
        else if (accept) dir_q <= in_dir;
    end
`else
    assign nxt_c = inv_c;
`endif

    always_comb begin
        fsm_d     = fsm_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                accept   = in_valid;
                if (in_valid) fsm_d = (in_rounds == '0) ? DONE : RUN;
            end
            RUN: begin
                if (cnt_q == ROUND_W'(1)) fsm_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
                busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            cnt_q   <= '0;
        end else begin
            fsm_q <= fsm_d;
            if (accept) begin
                state_q <= in_data;
                cnt_q   <= in_rounds;
            end else if (fsm_q == RUN) begin
                // RUN is only entered with a nonzero count, so this never wraps.
                state_q <= nxt_c;
                cnt_q   <= cnt_q - ROUND_W'(1);
            end
        end
    end

    assign out_data = state_q;

endmodule
